load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//   Data-memory access stage directly downstream of the execute ALU.
//   - Takes the ALU result as the effective address and rs2 as store data.
//   - Drives a req/gnt + rvalid data-memory port.
//   - Aligns and extends load data for writeback.
//   - Stalls the core (stall_o) until the access completes.
// PARAMETERS
//   XLEN      32   data/address width (only 32 supported)
// PORTS
//   clk_i          in   1     core clock, single clock domain
//   reset_i        in   1     synchronous, active-high reset
//   lsu_req_i      in   1     instruction in execute is a load/store
//   lsu_we_i       in   1     1=store, 0=load
//   lsu_size_i     in   2     mem_size_t: BYTE/HALF/WORD
//   lsu_zext_i     in   1     1=zero-extend load (LBU/LHU), 0=sign-extend
//   addr_i         in   32    effective address (ALU result)
//   wdata_i        in   32    store data (rs2)
//   stall_o        out  1     hold PC/pipeline while access in flight
//   done_o         out  1     access retires this cycle
//   rdata_o        out  32    aligned, extended load data; valid when done_o && !we
//   misaligned_o   out  1     misaligned access detected, no memory request issued
//   dmem_req_o     out  1     memory request
//   dmem_gnt_i     in   1     memory accepted request
//   dmem_addr_o    out  32    word address {addr[31:2],2'b00}
//   dmem_we_o      out  1     write enable
//   dmem_be_o      out  4     byte enables
//   dmem_wdata_o   out  32    lane-replicated store data
//   dmem_rvalid_i  in   1     load data valid (earliest: cycle after gnt)
//   dmem_rdata_i   in   32    raw memory word
// BEHAVIOUR
//   FSM states
//     IDLE -> REQ : lsu_req_i && !misaligned. Latch addr/size/zext/we/be/wdata.
//     REQ  -> RESP: on gnt for a load. REQ -> DONE: on gnt for a store.
//     RESP -> DONE: on rvalid. rdata_o is registered from the aligned dmem_rdata_i.
//     DONE -> IDLE: unconditionally. lsu_req_i is ignored in DONE, because the
//                   current instruction retires in this cycle.
//   rvalid handling: rvalid in REQ or IDLE is ignored.
//   Outputs
//     stall_o = (IDLE && lsu_req_i && !misaligned) || REQ || RESP.
//     done_o  = DONE.
//     dmem_req_o = REQ. All dmem_* outputs come from latched values and stay
//       stable while dmem_req_o && !dmem_gnt_i.
//   Misalignment (combinational, IDLE only)
//     Condition: HALF && addr[0], or WORD && addr[1:0]!=0.
//     Effect: misaligned_o=1 for that cycle, stall_o=0, no request, stay in IDLE.
//   Byte enables (off = addr[1:0])
//     BYTE: 4'b0001<<off.  HALF: 4'b0011<<off.  WORD: 4'b1111.
//   Store data: BYTE -> {4{wdata[7:0]}}, HALF -> {2{wdata[15:0]}}, WORD -> wdata.
//   Load data
//     Extract word>>(8*off), then take bits [7:0] or [15:0].
//     Sign- or zero-extend per zext. WORD is passed through.
//   Latency (zero-wait memory)
//     Store: 2 stall cycles, done in cycle 2.
//     Load:  3 stall cycles, done in cycle 3.
//   Reset values
//     State=IDLE, rdata_o=0, all dmem_* outputs=0, done_o=0.
//     stall_o and misaligned_o are gated to 0 while reset_i=1.
//   Reset mid-operation
//     Abandons the access and returns to IDLE.
//     A late rvalid/gnt afterwards is ignored and produces no done_o.
//   Illegal lsu_size_i (2'b11) is treated as misaligned.
// STRUCTURE
//   riscv_pkg additions
//     typedef enum logic [1:0] {BYTE=2'b00, HALF=2'b01, WORD=2'b10} mem_size_t;
//     typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_RESP, LSU_DONE} lsu_state_t;
//   Sub-module lsu_align (combinational)
//     Generates be, replicated wdata and misaligned.
//     Extracts and extends load data.
//     Instantiated twice: store side and load side.
//   load_store_unit holds the FSM and latches only.
// TESTING
//   1. SW addr=0x100 wdata=0xDEADBEEF, gnt in REQ
//      -> dmem_addr=0x100, be=4'b1111, we=1, stall 2 cycles, done_o in cycle 2.
//   2. LB addr=0x103 with rdata word 0x80FF1234, rvalid the cycle after gnt
//      -> rdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
//   3. SH addr=0x102 wdata=0x0000ABCD -> be=4'b1100, dmem_wdata=0xABCDABCD.
//      LH at 0x102 with word 0x8001_0000 -> rdata_o=0xFFFF8001.
//   4. LW addr=0x101 -> misaligned_o=1 for 1 cycle, dmem_req_o never high, stall_o=0.
//   5. gnt delayed 3 cycles, rvalid delayed 2 cycles after gnt
//      -> dmem_addr/be/we/wdata stable throughout.
//      -> stall_o continuous until DONE, exactly one done_o pulse.
//   6. reset_i pulsed while in RESP, rvalid arrives 1 cycle later
//      -> FSM in IDLE, done_o never asserted, rdata_o=0.
//      -> Next LW at 0x200 completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access sizes and FSM states.
package load_store_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RESP,
        LSU_DONE
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte enables, store replication, misalignment
// detection and load extraction/extension for one access description.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic            zext_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = '0;
        misaligned_o = 1'b0;
        rdata_o      = '0;
        shifted      = rdata_i >> {off_i, 3'b000};
        case (size_i)
            BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = zext_i ? {24'b0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                misaligned_o = off_i[0];
                be_o         = 4'b0011 << off_i;
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = zext_i ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            end
            WORD: begin
                misaligned_o = (off_i != 2'b00);
                be_o         = 4'b1111;
                wdata_o      = wdata_i;
                rdata_o      = rdata_i;
            end
            // 2'b11 is not a legal size; refuse it like a misaligned access
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: accepts a load/store from execute, runs the req/gnt/rvalid
// handshake and returns aligned load data, stalling the core meanwhile.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [1:0]      lsu_size_i,
    input  logic            lsu_zext_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o,
    output logic            dmem_req_o,
    input  logic            dmem_gnt_i,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    lsu_state_t      state_q, state_d;
    logic [XLEN-1:0] addr_q;
    logic [1:0]      size_q;
    logic            zext_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;

    logic            accept;
    logic            capture;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic            st_misaligned;
    logic [XLEN-1:0] st_unused_rdata;
    logic [3:0]      ld_unused_be;
    logic [XLEN-1:0] ld_unused_wdata;
    logic            ld_unused_misaligned;
    logic [XLEN-1:0] ld_rdata;

    // Store side works on the live request so the memory fields can be latched on accept
    load_store_unit_align u_st_align (
        .size_i       (lsu_size_i),
        .zext_i       (lsu_zext_i),
        .off_i        (addr_i[1:0]),
        .wdata_i      (wdata_i),
        .rdata_i      ('0),
        .be_o         (st_be),
        .wdata_o      (st_wdata),
        .misaligned_o (st_misaligned),
        .rdata_o      (st_unused_rdata)
    );

    load_store_unit_align u_ld_align (
        .size_i       (size_q),
        .zext_i       (zext_q),
        .off_i        (addr_q[1:0]),
        .wdata_i      ('0),
        .rdata_i      (dmem_rdata_i),
        .be_o         (ld_unused_be),
        .wdata_o      (ld_unused_wdata),
        .misaligned_o (ld_unused_misaligned),
        .rdata_o      (ld_rdata)
    );

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        capture      = 1'b0;
        stall_o      = 1'b0;
        misaligned_o = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (lsu_req_i && st_misaligned) begin
                    misaligned_o = 1'b1;
                end else if (lsu_req_i) begin
                    accept  = 1'b1;
                    stall_o = 1'b1;
                    state_d = LSU_REQ;
                end
            end
            LSU_REQ: begin
                stall_o = 1'b1;
                if (dmem_gnt_i) begin
                    state_d = we_q ? LSU_DONE : LSU_RESP;
                end
            end
            LSU_RESP: begin
                stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    capture = 1'b1;
                    state_d = LSU_DONE;
                end
            end
            // The instruction retires here, so a new lsu_req_i is not looked at
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
        if (reset_i) begin
            stall_o      = 1'b0;
            misaligned_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= LSU_IDLE;
            addr_q  <= '0;
            size_q  <= 2'b00;
            zext_q  <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= addr_i;
                size_q  <= lsu_size_i;
                zext_q  <= lsu_zext_i;
                we_q    <= lsu_we_i;
                be_q    <= st_be;
                wdata_q <= st_wdata;
            end
            if (capture) begin
                rdata_q <= ld_rdata;
            end
        end
    end

    assign done_o       = (state_q == LSU_DONE);
    assign dmem_req_o   = (state_q == LSU_REQ);
    assign dmem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
    assign dmem_we_o    = we_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign rdata_o      = rdata_q;

endmodule
